// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: shared ALU operation encoding, opcode/funct7 constants and the
// combinational instruction decode function used by rv_alu_decode_pipe.
package rv_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'h0,
    ALU_SUB     = 4'h1,
    ALU_AND     = 4'h2,
    ALU_OR      = 4'h3,
    ALU_XOR     = 4'h4,
    ALU_SLL     = 4'h5,
    ALU_SRL     = 4'h6,
    ALU_SRA     = 4'h7,
    ALU_SLT     = 4'h8,
    ALU_SLTU    = 4'h9,
    ALU_ILLEGAL = 4'hF
  } alu_op_e;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // Anything not explicitly matched falls through to ALU_ILLEGAL.
  function automatic alu_op_e alu_decode(input logic [6:0] opcode,
                                         input logic [2:0] funct3,
                                         input logic [6:0] funct7,
                                         input logic       en_imm);
    alu_op_e op;
    op = ALU_ILLEGAL;
    if (opcode == OPC_OP && funct7 == FUNCT7_BASE) begin
      case (funct3)
        3'b000:  op = ALU_ADD;
        3'b001:  op = ALU_SLL;
        3'b010:  op = ALU_SLT;
        3'b011:  op = ALU_SLTU;
        3'b100:  op = ALU_XOR;
        3'b101:  op = ALU_SRL;
        3'b110:  op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end else if (opcode == OPC_OP && funct7 == FUNCT7_ALT) begin
      case (funct3)
        3'b000:  op = ALU_SUB;
        3'b101:  op = ALU_SRA;
        default: op = ALU_ILLEGAL;
      endcase
    end else if (en_imm && opcode == OPC_OP_IMM) begin
      // funct7 is immediate data except for the shift encodings.
      case (funct3)
        3'b000:  op = ALU_ADD;
        3'b001:  op = (funct7 == FUNCT7_BASE) ? ALU_SLL : ALU_ILLEGAL;
        3'b010:  op = ALU_SLT;
        3'b011:  op = ALU_SLTU;
        3'b100:  op = ALU_XOR;
        3'b101:  op = (funct7 == FUNCT7_BASE) ? ALU_SRL :
                      (funct7 == FUNCT7_ALT)  ? ALU_SRA : ALU_ILLEGAL;
        3'b110:  op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/rv_alu_fifo.sv
// rv_alu_fifo: result buffer for the decode pipe.
// Ports: clk, rst (async, active-high); push/din write the tail, pop releases
// the head; flush empties synchronously; dout is the head entry, full/empty
// report occupancy. Push while full and pop while empty are ignored.
module rv_alu_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[head];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[tail] <= din;
  end

endmodule

// File: rtl/rv_alu_decode_pipe.sv
// rv_alu_decode_pipe: decodes RV32 OP / OP-IMM fields into an ALU op code and
// buffers results in a DEPTH-entry FIFO with valid/ready handshakes.
// Ports: clk, rst (async, active-high); in_valid/in_ready + opcode/funct3/
// funct7 request side; out_valid/out_ready + alu_op/illegal result side;
// flush discards buffered results; illegal_cnt counts accepted illegal
// requests (saturating), cleared by cnt_clr.
module rv_alu_decode_pipe
  import rv_alu_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter bit EN_IMM = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt,
  input  logic             cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  alu_op_e    dec_op;
  logic [3:0] head_op;
  logic       full;
  logic       empty;
  logic       accept;

  assign dec_op = alu_decode(opcode, funct3, funct7, EN_IMM);

  // rst term keeps in_ready low for the whole reset interval.
  assign in_ready = !full && !flush && !rst;
  assign accept   = in_valid && in_ready;

  rv_alu_fifo #(
    .DEPTH (DEPTH),
    .W     (4)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (dec_op),
    .pop   (out_ready),
    .flush (flush),
    .dout  (head_op),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign alu_op    = empty ? ALU_ILLEGAL : head_op;
  assign illegal   = !empty && (head_op == ALU_ILLEGAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (cnt_clr) begin
      illegal_cnt <= '0;
    end else if (accept && dec_op == ALU_ILLEGAL && illegal_cnt != CNT_MAX) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_alu_decode_pipe.sv
// Bench for rv_alu_decode_pipe: two instances (EN_IMM=1 and EN_IMM=0, both
// DEPTH=2, CNT_W=2) share stimulus; a queue-based reference model predicts
// handshakes, head results and the saturating illegal counter.
module tb_rv_alu_decode_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, flush, out_ready, cnt_clr;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic       in_ready1, out_valid1, illegal1;
  logic [3:0] alu_op1;
  logic [1:0] cnt1;
  logic       in_ready0, out_valid0, illegal0;
  logic [3:0] alu_op0;
  logic [1:0] cnt0;

  int checks   = 0;
  int failures = 0;

  int q1[$];
  int q0[$];
  int mcnt1, mcnt0;
  int r_tab[8] = '{0, 5, 8, 9, 4, 6, 3, 2};

  always #5 clk = ~clk;

  rv_alu_decode_pipe #(.DEPTH(2), .EN_IMM(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready), .alu_op(alu_op1),
    .illegal(illegal1), .illegal_cnt(cnt1), .cnt_clr(cnt_clr));

  rv_alu_decode_pipe #(.DEPTH(2), .EN_IMM(1'b0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .alu_op(alu_op0),
    .illegal(illegal0), .illegal_cnt(cnt0), .cnt_clr(cnt_clr));

  function automatic int ref_dec(input int opc, input int f3, input int f7, input bit en);
    if (opc == 'h33 && f7 == 0) return r_tab[f3];
    if (opc == 'h33 && f7 == 'h20) return (f3 == 0) ? 1 : (f3 == 5) ? 7 : 15;
    if (en && opc == 'h13) begin
      if (f3 == 1) return (f7 == 0) ? 5 : 15;
      if (f3 == 5) return (f7 == 0) ? 6 : (f7 == 'h20) ? 7 : 15;
      return r_tab[f3];
    end
    return 15;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":out_valid1"}, 32'(out_valid1), (q1.size() > 0) ? 1 : 0);
    chk({tag, ":alu_op1"}, 32'(alu_op1), (q1.size() > 0) ? q1[0] : 15);
    chk({tag, ":illegal1"}, 32'(illegal1), (q1.size() > 0 && q1[0] == 15) ? 1 : 0);
    chk({tag, ":cnt1"}, 32'(cnt1), mcnt1);
    chk({tag, ":out_valid0"}, 32'(out_valid0), (q0.size() > 0) ? 1 : 0);
    chk({tag, ":alu_op0"}, 32'(alu_op0), (q0.size() > 0) ? q0[0] : 15);
    chk({tag, ":illegal0"}, 32'(illegal0), (q0.size() > 0 && q0[0] == 15) ? 1 : 0);
    chk({tag, ":cnt0"}, 32'(cnt0), mcnt0);
  endtask

  // Called at a falling edge: drive, check in_ready, clock, update model, check.
  task automatic do_cycle(input string tag, input bit iv, input int opc, input int f3,
                          input int f7, input bit ordy, input bit fl, input bit clr);
    bit exp_ready, acc, pop;
    int d1, d0;
    in_valid  = iv;
    opcode    = 7'(opc);
    funct3    = 3'(f3);
    funct7    = 7'(f7);
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    #1;
    exp_ready = (q1.size() < 2) && !fl;
    chk({tag, ":in_ready1"}, 32'(in_ready1), 32'(exp_ready));
    chk({tag, ":in_ready0"}, 32'(in_ready0), 32'(exp_ready));
    acc = iv && exp_ready;
    pop = (q1.size() > 0) && ordy;
    d1  = ref_dec(opc, f3, f7, 1'b1);
    d0  = ref_dec(opc, f3, f7, 1'b0);
    @(posedge clk);
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (pop) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
      end
      if (acc) begin
        q1.push_back(d1);
        q0.push_back(d0);
      end
    end
    if (clr) begin
      mcnt1 = 0;
      mcnt0 = 0;
    end else if (acc) begin
      if (d1 == 15 && mcnt1 < 3) mcnt1++;
      if (d0 == 15 && mcnt0 < 3) mcnt0++;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    int opc, f3, f7;
    rst = 1'b1; in_valid = 0; opcode = 0; funct3 = 0; funct7 = 0;
    flush = 0; out_ready = 0; cnt_clr = 0;
    mcnt1 = 0; mcnt0 = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst:in_ready1", 32'(in_ready1), 0);
    check_outputs("rst");
    rst = 1'b0;

    // Basic decode, one-cycle latency
    do_cycle("add", 1, 'h33, 0, 'h00, 1, 0, 0);
    do_cycle("sub", 1, 'h33, 0, 'h20, 1, 0, 0);
    do_cycle("drain0", 0, 0, 0, 0, 1, 0, 0);

    // Backpressure: third request held until space frees, order preserved
    do_cycle("bp1", 1, 'h33, 4, 'h00, 0, 0, 0);
    do_cycle("bp2", 1, 'h33, 5, 'h20, 0, 0, 0);
    do_cycle("bp3", 1, 'h33, 6, 'h00, 0, 0, 0);
    do_cycle("bp4", 1, 'h33, 6, 'h00, 1, 0, 0);
    do_cycle("bp5", 0, 0, 0, 0, 1, 0, 0);
    do_cycle("bp6", 0, 0, 0, 0, 1, 0, 0);
    do_cycle("bp7", 0, 0, 0, 0, 1, 0, 0);

    // Immediate decode, both EN_IMM settings
    do_cycle("imm_sra", 1, 'h13, 5, 'h20, 1, 0, 0);
    do_cycle("imm_sll_bad", 1, 'h13, 1, 'h20, 1, 0, 0);
    do_cycle("imm_add", 1, 'h13, 0, 'h00, 1, 0, 0);
    do_cycle("imm_drain", 0, 0, 0, 0, 1, 0, 0);
    do_cycle("clr0", 0, 0, 0, 0, 1, 0, 1);

    // Saturating counter, then clear beating a same-cycle increment
    for (int i = 0; i < 5; i++) do_cycle("sat", 1, 'h7f, 0, 0, 1, 0, 0);
    do_cycle("clr_pri", 1, 'h7f, 0, 0, 1, 0, 1);
    do_cycle("clr_drain", 0, 0, 0, 0, 1, 0, 0);

    // Flush with a request present
    do_cycle("fl_a", 1, 'h33, 7, 'h00, 0, 0, 0);
    do_cycle("fl_b", 1, 'h33, 1, 'h00, 0, 0, 0);
    do_cycle("flush", 1, 'h33, 2, 'h00, 1, 1, 0);
    do_cycle("fl_after", 0, 0, 0, 0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    opc = 'h33;
        2:       opc = 'h13;
        default: opc = int'($urandom_range(0, 127));
      endcase
      f3 = int'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0, 1:    f7 = 0;
        2:       f7 = 'h20;
        default: f7 = int'($urandom_range(0, 127));
      endcase
      do_cycle("rand", ($urandom_range(0, 3) != 0), opc, f3, f7,
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset between edges with one entry buffered
    do_cycle("ar_drain1", 0, 0, 0, 0, 1, 0, 0);
    do_cycle("ar_drain2", 0, 0, 0, 0, 1, 0, 0);
    do_cycle("ar_push", 1, 'h33, 3, 'h00, 0, 0, 0);
    chk("ar_pre:out_valid1", 32'(out_valid1), 1);
    #2 rst = 1'b1;
    #1;
    q1.delete(); q0.delete(); mcnt1 = 0; mcnt0 = 0;
    chk("ar:in_ready1", 32'(in_ready1), 0);
    check_outputs("ar");
    @(negedge clk);
    rst = 1'b0;
    do_cycle("ar_post", 1, 'h33, 0, 'h20, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_alu_decode_pipe.md
RV_ALU_DECODE_PIPE -- requirements
Module: rv_alu_decode_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of output buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter EN_IMM, default 1, meaning I-type (opcode 0010011) decode enabled.
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of the illegal-instruction counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  decode request present.
REQ-007 SHALL have port in_ready  output  1  request accepted this cycle if in_valid.
REQ-008 SHALL have ports opcode  input  7, funct3  input  3, funct7  input  7  instruction fields.
REQ-009 SHALL have port flush  input  1  synchronous discard of all buffered results.
REQ-010 SHALL have port out_valid  output  1  buffered result present at head.
REQ-011 SHALL have port out_ready  input  1  consumer takes head this cycle if out_valid.
REQ-012 SHALL have port alu_op  output  4  head result operation code (alu_op_e).
REQ-013 SHALL have port illegal  output  1  head result is illegal (alu_op == 4'hF).
REQ-014 SHALL have port illegal_cnt  output  CNT_W  saturating count of accepted illegal requests.
REQ-015 SHALL have port cnt_clr  input  1  synchronous clear of illegal_cnt.

Function
REQ-016 SHALL encode alu_op: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, ILLEGAL 4'hF; values 10..14 never produced.
REQ-017 SHALL decode opcode 0110011 with funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
REQ-018 SHALL decode opcode 0110011 with funct7 0100000: funct3 000 SUB, 101 SRA; all other funct3 ILLEGAL.
REQ-019 SHALL, when EN_IMM=1, decode opcode 0010011 ignoring funct7: 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; 001 SLL only if funct7=0000000; 101 SRL if funct7=0000000, SRA if 0100000; otherwise ILLEGAL.
REQ-020 SHALL return ILLEGAL for every other opcode/funct combination, and for opcode 0010011 when EN_IMM=0.
REQ-021 SHALL accept a request when in_valid && in_ready and write its decoded result into the buffer tail.
REQ-022 SHALL drive in_ready = !full && !flush (no combinational dependence on out_ready).
REQ-023 SHALL drive out_valid = !empty; alu_op/illegal from the head entry, 4'hF/0 when empty.
REQ-024 SHALL pop the head when out_valid && out_ready.
REQ-025 SHALL give minimum latency one cycle: request accepted at edge N appears with out_valid high after edge N.
REQ-026 SHALL support simultaneous push and pop when neither full nor empty, occupancy unchanged; when full, only pop occurs.
REQ-027 SHALL preserve acceptance order; head/tail pointers wrap modulo DEPTH.
REQ-028 SHALL, on flush, empty the buffer at the next edge regardless of out_ready; no pop is counted as delivered.
REQ-029 SHALL increment illegal_cnt by 1 per accepted ILLEGAL request, saturating at 2**CNT_W-1.
REQ-030 SHALL give cnt_clr priority over a same-cycle increment (result 0).

Reset
REQ-031 SHALL, while rst is high, hold buffer empty, out_valid=0, in_ready=0, alu_op=4'hF, illegal=0, illegal_cnt=0.
REQ-032 SHALL discard buffered results if rst asserts mid-operation; in_ready rises the first cycle after rst deasserts.

Structure
REQ-033 SHALL place alu_op_e, OPC_OP (0110011), OPC_OP_IMM (0010011), FUNCT7_BASE, FUNCT7_ALT in shared package rv_alu_pkg.
REQ-034 SHALL implement decode as a pure combinational function in rv_alu_pkg and buffering in one sub-module rv_alu_fifo.

Verification
REQ-035 SHALL check: reset, then {0000000,000,0110011} then {0100000,000,0110011}, out_ready=1 -> alu_op 0 then 1, one cycle after each accept.
REQ-036 SHALL check: out_ready=0, push 3 requests with DEPTH=2 -> in_ready low after 2nd accept; 3rd held; release -> order preserved.
REQ-037 SHALL check: EN_IMM=1 {0100000,101,0010011} -> 7; {0100000,001,0010011} -> 4'hF, illegal=1; EN_IMM=0 {0000000,000,0010011} -> 4'hF.
REQ-038 SHALL check: CNT_W=2, accept 5 illegal requests -> illegal_cnt 3; cnt_clr with same-cycle illegal accept -> 0.
REQ-039 SHALL check: 2 entries buffered, flush with in_valid high -> out_valid 0 next cycle, request not accepted, buffer empty.
REQ-040 SHALL check: rst asserted asynchronously between edges with 1 entry buffered -> out_valid 0 immediately, alu_op 4'hF.
